ahb_multi_arbiter: RTL and testbench

Parametrised AHB-Lite multi-master bus arbiter sitting between N masters and the shared address/data mux. It is the next generation of the 4-master round-robin arbiter. It adds:
- configurable master count;
- selectable fixed-priority or round-robin policy;
- a default master;
- locked-transfer support (HMASTLOCK);
- a fairness cap on undefined-length INCR bursts;
- ERROR-response burst termination.

HGRANT is registered. HMASTER follows the grant on HREADY, so ownership changes only at address-phase boundaries.

---
 rtl/ahb_multi_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_ahb_multi_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_multi_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_multi_arbiter
//
// AHB-Lite multi-master bus arbiter. Selects which of NUM_MASTERS masters
// owns the shared address/data mux. Arbitration is round-robin or fixed
// priority. Burst tracking keeps ownership stable inside fixed-length bursts
// and inside locked sequences. Undefined-length INCR bursts are cut after
// MAX_INCR_BEATS beats so one master cannot starve the others.
//
// Handshake: a beat is accepted on a rising HCLK edge where HREADY=1 and
// HTRANS is NONSEQ or SEQ. HREADY=0 stalls HMASTER/HMASTLOCK and the burst
// counters. HGRANT is a registered one-hot vector. HMASTER/HMASTLOCK follow
// HGRANT on the next edge with HREADY=1, so ownership only changes at
// address-phase boundaries.
//
// Ports
//   HCLK, HRESETn      clock, asynchronous active-low reset
//   HBUSREQ, HLOCK     per-master request / lock request
//   HREADY             global transfer-ready
//   HTRANS, HBURST     transfer/burst type of the current owner
//   HRESP              slave response (ERROR=01 terminates the burst)
//   HGRANT             one-hot registered grant
//   HMASTER            index of the address-phase owner
//   HMASTLOCK          current transfer is locked
//   burst_state_dbg    burst FSM state (0=OPEN, 1=FIXED, 2=INCR)
// ---------------------------------------------------------------------------
module ahb_multi_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = 0,
   parameter int PRIORITY_MODE  = 0,
   parameter int MAX_INCR_BEATS = 16,
   localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                   HCLK,
   input  logic                   HRESETn,
   input  logic [NUM_MASTERS-1:0] HBUSREQ,
   input  logic [NUM_MASTERS-1:0] HLOCK,
   input  logic                   HREADY,
   input  logic [1:0]             HTRANS,
   input  logic [2:0]             HBURST,
   input  logic [1:0]             HRESP,
   output logic [NUM_MASTERS-1:0] HGRANT,
   output logic [MW-1:0]          HMASTER,
   output logic                   HMASTLOCK,
   output logic [1:0]             burst_state_dbg
);

   localparam int BW = (MAX_INCR_BEATS > 0) ? $clog2(MAX_INCR_BEATS + 1) : 1;
   localparam logic [NUM_MASTERS-1:0] RESET_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
   localparam logic [MW-1:0]          DEFAULT_IDX = MW'(DEFAULT_MASTER);
   localparam logic [BW-1:0]          BEAT_CAP    = BW'(MAX_INCR_BEATS);

   typedef enum logic [1:0] {
      ST_OPEN  = 2'd0,
      ST_FIXED = 2'd1,
      ST_INCR  = 2'd2
   } burst_state_e;

   burst_state_e             state_q, state_d, start_state;
   logic [3:0]               remaining_q, remaining_d, start_rem;
   logic [BW-1:0]            beats_q, beats_d, beats_inc, start_beats;
   logic [NUM_MASTERS-1:0]   grant_q, grant_d;
   logic [MW-1:0]            master_q, master_d;
   logic                     mastlock_q, mastlock_d;

   logic [MW-1:0]            grant_idx;
   logic [MW-1:0]            next_master;
   logic                     found;
   logic                     handover_ok;
   logic                     beat_ok, trans_nonseq, trans_seq, idle_ok;
   logic                     start_burst, cap_hit, resp_error;

   // ------------------------------------------------------------------------
   // Transfer decode
   // ------------------------------------------------------------------------
   assign trans_nonseq = (HTRANS == 2'b10);
   assign trans_seq    = (HTRANS == 2'b11);
   assign beat_ok      = HREADY && HTRANS[1];
   assign idle_ok      = HREADY && (HTRANS == 2'b00);
   assign resp_error   = (HRESP == 2'b01);
   // A NONSEQ inside a fixed burst is a protocol error; only OPEN and INCR
   // may begin a new burst.
   assign start_burst  = beat_ok && trans_nonseq && (state_q != ST_FIXED);
   assign cap_hit      = (MAX_INCR_BEATS != 0) && (beats_q == BEAT_CAP);

   // Burst type decode: what a NONSEQ with this HBURST would start.
   always_comb begin
      start_state = ST_OPEN;
      start_rem   = 4'd0;
      start_beats = '0;
      if (HBURST == 3'b001) begin
         start_state = ST_INCR;
         start_beats = BW'(1);
      end else begin
         case (HBURST[2:1])
            2'b01:   begin start_state = ST_FIXED; start_rem = 4'd3;  end
            2'b10:   begin start_state = ST_FIXED; start_rem = 4'd7;  end
            2'b11:   begin start_state = ST_FIXED; start_rem = 4'd15; end
            default: begin start_state = ST_OPEN;  start_rem = 4'd0;  end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Burst FSM (next state)
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      beats_d     = beats_q;
      beats_inc   = beats_q + 1'b1;
      case (state_q)
         ST_OPEN: begin
            if (start_burst) begin
               state_d     = start_state;
               remaining_d = start_rem;
               beats_d     = start_beats;
            end
         end
         ST_FIXED: begin
            if (beat_ok && trans_seq) begin
               if (remaining_q == 4'd1) begin
                  state_d     = ST_OPEN;
                  remaining_d = 4'd0;
               end else begin
                  remaining_d = remaining_q - 4'd1;
               end
            end
         end
         ST_INCR: begin
            if (!HBUSREQ[master_q] || idle_ok || cap_hit) begin
               state_d = ST_OPEN;
               beats_d = '0;
            end else if (start_burst) begin
               state_d     = start_state;
               remaining_d = start_rem;
               beats_d     = start_beats;
            end else if (beat_ok && trans_seq && (MAX_INCR_BEATS != 0)) begin
               // Leave on the edge that accepts the capping beat so the
               // grant can move one cycle later, like a fixed burst.
               if (beats_inc == BEAT_CAP) begin
                  state_d = ST_OPEN;
                  beats_d = '0;
               end else begin
                  beats_d = beats_inc;
               end
            end
         end
         default: begin
            state_d = ST_OPEN;
         end
      endcase
      if (resp_error) begin
         state_d     = ST_OPEN;
         remaining_d = 4'd0;
         beats_d     = '0;
      end
   end

   // ------------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------------
   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant_q[i]) grant_idx = MW'(i);
      end
   end

   always_comb begin
      next_master = DEFAULT_IDX;
      found       = 1'b0;
      if (|HBUSREQ) begin
         if (PRIORITY_MODE != 0) begin
            // Descending scan: the last hit is the lowest index.
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
               if (HBUSREQ[i]) next_master = MW'(i);
            end
         end else begin
            // Search starts after the owner; k == NUM_MASTERS wraps back to
            // the owner itself so a lone owner keeps the bus.
            for (int k = 1; k <= NUM_MASTERS; k++) begin
               if (!found && HBUSREQ[(int'(master_q) + k) % NUM_MASTERS]) begin
                  next_master = MW'((int'(master_q) + k) % NUM_MASTERS);
                  found       = 1'b1;
               end
            end
         end
      end
   end

   assign handover_ok = (state_q == ST_OPEN) && !(mastlock_q && HLOCK[master_q]);

   always_comb begin
      grant_d    = grant_q;
      master_d   = master_q;
      mastlock_d = mastlock_q;
      if (handover_ok) begin
         grant_d              = '0;
         grant_d[next_master] = 1'b1;
      end
      if (HREADY) begin
         master_d   = grant_idx;
         mastlock_d = HLOCK[grant_idx];
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= ST_OPEN;
         remaining_q <= 4'd0;
         beats_q     <= '0;
         grant_q     <= RESET_GRANT;
         master_q    <= DEFAULT_IDX;
         mastlock_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         beats_q     <= beats_d;
         grant_q     <= grant_d;
         master_q    <= master_d;
         mastlock_q  <= mastlock_d;
      end
   end

   assign HGRANT          = grant_q;
   assign HMASTER         = master_q;
   assign HMASTLOCK       = mastlock_q;
   assign burst_state_dbg = state_q;

endmodule

// File: tb/tb_ahb_multi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_multi_arbiter
//
// Three arbiter instances share one set of input drivers:
//   A: 4 masters, default 2, round-robin, INCR cap 16
//   B: 4 masters, default 0, round-robin, INCR cap 4
//   C: 4 masters, default 0, fixed priority, INCR cap 16
// Each expectation carries the instance it applies to. Inputs change on the
// falling edge; expected outputs after the following rising edge are queued
// and checked 1 time unit after that edge by the monitor.
// ---------------------------------------------------------------------------
module tb_ahb_multi_arbiter;

   localparam logic [1:0] D_A = 2'd0, D_B = 2'd1, D_C = 2'd2;
   localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSQ = 2'b10, SEQ = 2'b11;
   localparam logic [2:0] SGL = 3'b000, INC = 3'b001, I4 = 3'b011, I8 = 3'b101, W16 = 3'b110;
   localparam logic [1:0] OK = 2'b00, ERR = 2'b01;
   localparam logic [1:0] S_OPEN = 2'd0, S_FIX = 2'd1, S_INC = 2'd2, S_ANY = 2'd3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] hbusreq = '0;
   logic [3:0] hlock   = '0;
   logic       hready  = 1'b1;
   logic [1:0] htrans  = IDLE;
   logic [2:0] hburst  = SGL;
   logic [1:0] hresp   = OK;

   logic [3:0] hgrant [3];
   logic [1:0] hmaster [3];
   logic       hmastlock [3];
   logic [1:0] bstate [3];

   ahb_multi_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(2), .PRIORITY_MODE(0), .MAX_INCR_BEATS(16)) u_dut_a (
      .HCLK(clk), .HRESETn(rst_n), .HBUSREQ(hbusreq), .HLOCK(hlock), .HREADY(hready),
      .HTRANS(htrans), .HBURST(hburst), .HRESP(hresp), .HGRANT(hgrant[0]),
      .HMASTER(hmaster[0]), .HMASTLOCK(hmastlock[0]), .burst_state_dbg(bstate[0]));

   ahb_multi_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0), .PRIORITY_MODE(0), .MAX_INCR_BEATS(4)) u_dut_b (
      .HCLK(clk), .HRESETn(rst_n), .HBUSREQ(hbusreq), .HLOCK(hlock), .HREADY(hready),
      .HTRANS(htrans), .HBURST(hburst), .HRESP(hresp), .HGRANT(hgrant[1]),
      .HMASTER(hmaster[1]), .HMASTLOCK(hmastlock[1]), .burst_state_dbg(bstate[1]));

   ahb_multi_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0), .PRIORITY_MODE(1), .MAX_INCR_BEATS(16)) u_dut_c (
      .HCLK(clk), .HRESETn(rst_n), .HBUSREQ(hbusreq), .HLOCK(hlock), .HREADY(hready),
      .HTRANS(htrans), .HBURST(hburst), .HRESP(hresp), .HGRANT(hgrant[2]),
      .HMASTER(hmaster[2]), .HMASTLOCK(hmastlock[2]), .burst_state_dbg(bstate[2]));

   // ---------------- scoreboard ----------------
   // Packed expectation: {dut[1:0], grant[3:0], master[1:0], lock, state[1:0]}
   logic [10:0] exp_q[$];
   string       name_q[$];
   int          tests_run = 0;
   int          tests_failed = 0;

   task automatic compare(input string nm, input logic [10:0] e);
      int         d;
      logic [3:0] ag;
      logic [1:0] am, as_;
      logic       al;
      d   = int'(e[10:9]);
      ag  = hgrant[d];
      am  = hmaster[d];
      al  = hmastlock[d];
      as_ = bstate[d];
      tests_run++;
      if (ag !== e[8:5] || am !== e[4:3] || al !== e[2] ||
          (e[1:0] != S_ANY && as_ !== e[1:0])) begin
         tests_failed++;
         $display("FAIL %s (dut %0d): got grant=%b master=%0d lock=%b state=%0d, expected grant=%b master=%0d lock=%b state=%0d",
                  nm, d, ag, am, al, as_, e[8:5], e[4:3], e[2], e[1:0]);
      end
   endtask

   // Monitor: the arbiter presents a new output every edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) compare(name_q.pop_front(), exp_q.pop_front());
   end

   // ---------------- driver tasks ----------------
   task automatic step(input string nm, input logic [1:0] d, input logic [3:0] req, input logic [3:0] lk,
                       input logic rdy, input logic [1:0] tr, input logic [2:0] bu, input logic [1:0] rs,
                       input logic [3:0] eg, input logic [1:0] em, input logic el, input logic [1:0] es);
      @(negedge clk);
      hbusreq = req; hlock = lk; hready = rdy; htrans = tr; hburst = bu; hresp = rs;
      exp_q.push_back({d, eg, em, el, es});
      name_q.push_back(nm);
   endtask

   task automatic check_reset_values(input string nm);
      compare(nm, {D_A, 4'b0100, 2'd2, 1'b0, S_OPEN});
      compare(nm, {D_B, 4'b0001, 2'd0, 1'b0, S_OPEN});
      compare(nm, {D_C, 4'b0001, 2'd0, 1'b0, S_OPEN});
   endtask

   task automatic do_reset(input string nm);
      @(negedge clk);
      hbusreq = '0; hlock = '0; hready = 1'b1; htrans = IDLE; hburst = SGL; hresp = OK;
      rst_n = 1'b0;
      #1 check_reset_values(nm);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Reset, then idle: default master keeps the grant.
      do_reset("reset_a");
      for (int i = 0; i < 3; i++)
         step("idle_default", D_A, 4'b0000, 4'b0000, 1, IDLE, SGL, OK, 4'b0100, 2'd2, 0, S_OPEN);

      // Round-robin from owner 1 with all masters requesting.
      do_reset("reset_rr");
      step("rr_setup0", D_A, 4'b0010, 4'b0000, 1, IDLE, SGL, OK, 4'b0010, 2'd2, 0, S_OPEN);
      step("rr_setup1", D_A, 4'b0010, 4'b0000, 1, IDLE, SGL, OK, 4'b0010, 2'd1, 0, S_OPEN);
      step("rr_g2a", D_A, 4'b1111, 4'b0000, 1, NSQ, SGL, OK, 4'b0100, 2'd1, 0, S_OPEN);
      step("rr_g2b", D_A, 4'b1111, 4'b0000, 1, NSQ, SGL, OK, 4'b0100, 2'd2, 0, S_OPEN);
      step("rr_g3a", D_A, 4'b1111, 4'b0000, 1, NSQ, SGL, OK, 4'b1000, 2'd2, 0, S_OPEN);
      step("rr_g3b", D_A, 4'b1111, 4'b0000, 1, NSQ, SGL, OK, 4'b1000, 2'd3, 0, S_OPEN);
      step("rr_g0a", D_A, 4'b1111, 4'b0000, 1, NSQ, SGL, OK, 4'b0001, 2'd3, 0, S_OPEN);
      step("rr_g0b", D_A, 4'b1111, 4'b0000, 1, NSQ, SGL, OK, 4'b0001, 2'd0, 0, S_OPEN);
      step("rr_g1a", D_A, 4'b1111, 4'b0000, 1, NSQ, SGL, OK, 4'b0010, 2'd0, 0, S_OPEN);
      step("rr_g1b", D_A, 4'b1111, 4'b0000, 1, NSQ, SGL, OK, 4'b0010, 2'd1, 0, S_OPEN);
      step("rr_g2c", D_A, 4'b1111, 4'b0000, 1, NSQ, SGL, OK, 4'b0100, 2'd1, 0, S_OPEN);

      // INCR8 from master 0 with two wait states; master 3 waits.
      do_reset("reset_incr8");
      step("i8_setup0", D_A, 4'b0001, 4'b0000, 1, IDLE, SGL, OK, 4'b0001, 2'd2, 0, S_OPEN);
      step("i8_setup1", D_A, 4'b0001, 4'b0000, 1, IDLE, SGL, OK, 4'b0001, 2'd0, 0, S_OPEN);
      step("i8_beat1", D_A, 4'b0001, 4'b0000, 1, NSQ, I8, OK, 4'b0001, 2'd0, 0, S_FIX);
      for (int b = 2; b <= 4; b++)
         step("i8_beat_lo", D_A, 4'b1001, 4'b0000, 1, SEQ, I8, OK, 4'b0001, 2'd0, 0, S_FIX);
      step("i8_wait1", D_A, 4'b1001, 4'b0000, 0, SEQ, I8, OK, 4'b0001, 2'd0, 0, S_FIX);
      step("i8_wait2", D_A, 4'b1001, 4'b0000, 0, SEQ, I8, OK, 4'b0001, 2'd0, 0, S_FIX);
      for (int b = 5; b <= 7; b++)
         step("i8_beat_hi", D_A, 4'b1001, 4'b0000, 1, SEQ, I8, OK, 4'b0001, 2'd0, 0, S_FIX);
      step("i8_beat8", D_A, 4'b1001, 4'b0000, 1, SEQ, I8, OK, 4'b0001, 2'd0, 0, S_OPEN);
      step("i8_handover", D_A, 4'b1000, 4'b0000, 1, IDLE, SGL, OK, 4'b1000, 2'd0, 0, S_OPEN);
      step("i8_owner3", D_A, 4'b1000, 4'b0000, 1, IDLE, SGL, OK, 4'b1000, 2'd3, 0, S_OPEN);

      // Lock: master 0 locked SINGLE transfers hold the grant against master 1.
      do_reset("reset_lock");
      step("lk_setup0", D_A, 4'b0001, 4'b0001, 1, IDLE, SGL, OK, 4'b0001, 2'd2, 0, S_OPEN);
      step("lk_setup1", D_A, 4'b0001, 4'b0001, 1, IDLE, SGL, OK, 4'b0001, 2'd0, 1, S_OPEN);
      step("lk_hold1", D_A, 4'b0011, 4'b0001, 1, NSQ, SGL, OK, 4'b0001, 2'd0, 1, S_OPEN);
      step("lk_hold2", D_A, 4'b0011, 4'b0001, 1, NSQ, SGL, OK, 4'b0001, 2'd0, 1, S_OPEN);
      step("lk_release", D_A, 4'b0011, 4'b0000, 0, IDLE, SGL, OK, 4'b0010, 2'd0, 1, S_OPEN);
      step("lk_clear", D_A, 4'b0011, 4'b0000, 1, IDLE, SGL, OK, 4'b0010, 2'd1, 0, S_OPEN);
      step("lk_default", D_A, 4'b0000, 4'b0000, 1, IDLE, SGL, OK, 4'b0100, 2'd1, 0, S_OPEN);

      // INCR cap of 4 beats on instance B; BUSY does not count.
      do_reset("reset_cap");
      step("cap_setup0", D_B, 4'b0010, 4'b0000, 1, IDLE, SGL, OK, 4'b0010, 2'd0, 0, S_OPEN);
      step("cap_setup1", D_B, 4'b0010, 4'b0000, 1, IDLE, SGL, OK, 4'b0010, 2'd1, 0, S_OPEN);
      step("cap_beat1", D_B, 4'b0010, 4'b0000, 1, NSQ, INC, OK, 4'b0010, 2'd1, 0, S_INC);
      step("cap_beat2", D_B, 4'b0110, 4'b0000, 1, SEQ, INC, OK, 4'b0010, 2'd1, 0, S_INC);
      step("cap_busy", D_B, 4'b0110, 4'b0000, 1, BUSY, INC, OK, 4'b0010, 2'd1, 0, S_INC);
      step("cap_beat3", D_B, 4'b0110, 4'b0000, 1, SEQ, INC, OK, 4'b0010, 2'd1, 0, S_INC);
      step("cap_beat4", D_B, 4'b0110, 4'b0000, 1, SEQ, INC, OK, 4'b0010, 2'd1, 0, S_OPEN);
      step("cap_handover", D_B, 4'b0110, 4'b0000, 1, SEQ, INC, OK, 4'b0100, 2'd1, 0, S_OPEN);
      step("cap_owner2", D_B, 4'b0110, 4'b0000, 1, IDLE, SGL, OK, 4'b0100, 2'd2, 0, S_OPEN);
      // Burst start wins over a simultaneous request drop; drop ends INCR next.
      step("incr_start_wins", D_B, 4'b0000, 4'b0000, 1, NSQ, INC, OK, 4'b0001, 2'd2, 0, S_INC);
      step("incr_req_drop", D_B, 4'b0000, 4'b0000, 1, SEQ, INC, OK, 4'b0001, 2'd0, 0, S_OPEN);

      // Fixed priority + ERROR termination on instance C.
      do_reset("reset_prio");
      step("fp_setup0", D_C, 4'b0100, 4'b0000, 1, IDLE, SGL, OK, 4'b0100, 2'd0, 0, S_OPEN);
      step("fp_setup1", D_C, 4'b0100, 4'b0000, 1, IDLE, SGL, OK, 4'b0100, 2'd2, 0, S_OPEN);
      step("fp_w16_beat1", D_C, 4'b0100, 4'b0000, 1, NSQ, W16, OK, 4'b0100, 2'd2, 0, S_FIX);
      step("fp_w16_beat2", D_C, 4'b1110, 4'b0000, 1, SEQ, W16, OK, 4'b0100, 2'd2, 0, S_FIX);
      step("fp_err_cycle1", D_C, 4'b1110, 4'b0000, 0, SEQ, W16, ERR, 4'b0100, 2'd2, 0, S_OPEN);
      step("fp_err_cycle2", D_C, 4'b1110, 4'b0000, 1, IDLE, SGL, ERR, 4'b0010, 2'd2, 0, S_OPEN);
      step("fp_owner1", D_C, 4'b1110, 4'b0000, 1, IDLE, SGL, OK, 4'b0010, 2'd1, 0, S_OPEN);
      step("fp_i4_beat1", D_C, 4'b1110, 4'b0000, 1, NSQ, I4, OK, 4'b0010, 2'd1, 0, S_FIX);
      step("fp_i4_beat2", D_C, 4'b1110, 4'b0000, 1, SEQ, I4, OK, 4'b0010, 2'd1, 0, S_FIX);

      // Asynchronous reset mid-burst, checked before the next rising edge.
      @(negedge clk);
      rst_n = 1'b0;
      htrans = IDLE; hburst = SGL;
      #1 check_reset_values("async_reset_mid_burst");
      @(negedge clk);
      check_reset_values("reset_held");
      rst_n = 1'b1;
      exp_q.push_back({D_C, 4'b0010, 2'd0, 1'b0, S_OPEN});
      name_q.push_back("first_arb_after_release");
      step("fp_after_release", D_C, 4'b1110, 4'b0000, 1, IDLE, SGL, OK, 4'b0010, 2'd1, 0, S_OPEN);

      // Drain.
      repeat (3) @(negedge clk);
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Hard bound on run time.
   initial begin
      #100000;
      $display("FAIL timeout: bench still running at %0t, expected to have finished", $time);
      $fatal(1, "timeout");
   end

endmodule
